// File: rtl/regfile_pkg.sv
// Shared types and sizes for the integer register file and its scoreboard.
// Index 31 is the hardwired zero register.
package regfile_pkg;
  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  localparam logic [ADDR_W-1:0] XZR = 5'd31;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/decoder_5x32.sv
// One-hot enable decoder for register indices.
// The zero register never receives an enable.
module decoder_5x32
  import regfile_pkg::*;
(
  input  logic                en_i,
  input  reg_idx_t            addr_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i && (addr_i != XZR)) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32 x 64 register file, two read ports, one write port,
// with a per-register busy scoreboard between ID and WB.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WR_BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  reg_idx_t            rd_addr1,
  input  reg_idx_t            rd_addr2,
  output word_t               rd_data1,
  output word_t               rd_data2,
  output logic                rd_busy1,
  output logic                rd_busy2,
  input  logic                wr_en,
  input  reg_idx_t            wr_addr,
  input  word_t               wr_data,
  input  logic                alloc_en,
  input  reg_idx_t            alloc_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  word_t               regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] wr_oh;
  logic [NUM_REGS-1:0] al_oh;
  logic                byp1;
  logic                byp2;

  decoder_5x32 u_wr_dec (
    .en_i     (wr_en),
    .addr_i   (wr_addr),
    .onehot_o (wr_oh)
  );

  decoder_5x32 u_al_dec (
    .en_i     (alloc_en),
    .addr_i   (alloc_addr),
    .onehot_o (al_oh)
  );

  // Set after clear: a newer producer keeps the register busy.
  assign busy_d = (busy_q & ~wr_oh) | al_oh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_oh[i]) begin
          regs_q[i] <= wr_data;
        end
      end
      busy_q <= busy_d;
    end
  end

  assign byp1 = (WR_BYPASS != 0) && wr_en
             && (wr_addr == rd_addr1);
  assign byp2 = (WR_BYPASS != 0) && wr_en
             && (wr_addr == rd_addr2);

  assign rd_data1 = (rd_addr1 == XZR) ? '0
                  : byp1 ? wr_data
                  : regs_q[rd_addr1];
  assign rd_data2 = (rd_addr2 == XZR) ? '0
                  : byp2 ? wr_data
                  : regs_q[rd_addr2];

  assign rd_busy1 = busy_q[rd_addr1];
  assign rd_busy2 = busy_q[rd_addr2];
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Random and directed checks of regfile_scoreboard against a
// simple array model, for both bypass settings.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        alloc_en = 1'b0;
  logic [4:0]  alloc_addr = '0;

  logic [63:0] rd_data1, rd_data2;
  logic        rd_busy1, rd_busy2;
  logic [31:0] busy_vec;
  logic [63:0] nb_data1, nb_data2;
  logic        nb_busy1, nb_busy2;
  logic [31:0] nb_bvec;

  int total = 0;
  int bad = 0;

  logic [63:0] m_reg [32];
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  regfile_scoreboard #(.WR_BYPASS(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy_vec(busy_vec)
  );

  regfile_scoreboard #(.WR_BYPASS(0)) u_nb (
    .clk(clk), .reset_n(reset_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(nb_data1), .rd_data2(nb_data2),
    .rd_busy1(nb_busy1), .rd_busy2(nb_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy_vec(nb_bvec)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] a,
                                         input bit byp);
    if (a == 5'd31) return '0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_busy = '0;
  endtask

  task automatic m_edge();
    logic [31:0] nb;
    if (!reset_n) return;
    nb = m_busy;
    if (wr_en && wr_addr != 5'd31) begin
      m_reg[wr_addr] = wr_data;
      nb[wr_addr] = 1'b0;
    end
    if (alloc_en && alloc_addr != 5'd31) nb[alloc_addr] = 1'b1;
    m_busy = nb;
  endtask

  task automatic step();
    #1;
    chk("rd1", rd_data1, exp_rd(rd_addr1, 1'b1));
    chk("rd2", rd_data2, exp_rd(rd_addr2, 1'b1));
    chk("nb_rd1", nb_data1, exp_rd(rd_addr1, 1'b0));
    chk("nb_rd2", nb_data2, exp_rd(rd_addr2, 1'b0));
    chk("busy1", {63'd0, rd_busy1}, {63'd0, m_busy[rd_addr1]});
    chk("busy2", {63'd0, rd_busy2}, {63'd0, m_busy[rd_addr2]});
    chk("bvec", {32'd0, busy_vec}, {32'd0, m_busy});
    chk("nb_bvec", {32'd0, nb_bvec}, {32'd0, m_busy});
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0;
    alloc_en = 1'b0;
  endtask

  initial begin
    m_clear();
    @(negedge clk);
    #1;
    chk("rst_rd1", rd_data1, 64'd0);
    chk("rst_bvec", {32'd0, busy_vec}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Write reg5 and mark it busy, then reset mid-cycle
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF;
    alloc_en = 1'b1; alloc_addr = 5'd5;
    step();
    idle(); rd_addr1 = 5'd5;
    #1;
    chk("pre_rst5", rd_data1, 64'hDEAD_BEEF);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst5", rd_data1, 64'd0);
    chk("mid_rst_bv", {32'd0, busy_vec}, 64'd0);
    m_clear();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("post_rst5", rd_data1, 64'd0);

    // Plain write, read both ports next cycle
    wr_en = 1'b1; wr_addr = 5'd3;
    wr_data = 64'h0123_4567_89AB_CDEF;
    step();
    idle(); rd_addr1 = 5'd3; rd_addr2 = 5'd3;
    #1;
    chk("r3_p1", rd_data1, 64'h0123_4567_89AB_CDEF);
    chk("r3_p2", rd_data2, 64'h0123_4567_89AB_CDEF);
    step();

    // Zero register ignores write and alloc
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
    alloc_en = 1'b1; alloc_addr = 5'd31;
    rd_addr1 = 5'd31;
    step();
    idle(); rd_addr1 = 5'd31; rd_addr2 = 5'd31;
    #1;
    chk("xzr_rd1", rd_data1, 64'd0);
    chk("xzr_rd2", rd_data2, 64'd0);
    chk("xzr_busy", {63'd0, busy_vec[31]}, 64'd0);
    step();

    // Same-cycle bypass vs. no bypass
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h55;
    rd_addr1 = 5'd7;
    #1;
    chk("byp1", rd_data1, 64'h55);
    chk("nobyp1", nb_data1, 64'd0);
    step();

    // Busy lifetime of reg9
    idle(); alloc_en = 1'b1; alloc_addr = 5'd9;
    step();
    idle(); rd_addr2 = 5'd9;
    #1 chk("b9_c1", {63'd0, rd_busy2}, 64'd1);
    step();
    step();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h9999;
    #1 chk("b9_c3", {63'd0, rd_busy2}, 64'd1);
    step();
    idle();
    #1 chk("b9_c4", {63'd0, rd_busy2}, 64'd0);
    step();

    // Alloc and write the same busy register together
    alloc_en = 1'b1; alloc_addr = 5'd12;
    step();
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'hC0FFEE_0012;
    alloc_en = 1'b1; alloc_addr = 5'd12;
    step();
    idle(); rd_addr1 = 5'd12;
    #1;
    chk("b12_set", {63'd0, busy_vec[12]}, 64'd1);
    chk("r12_val", rd_data1, 64'hC0FFEE_0012);
    step();

    // Random traffic with occasional mid-run resets
    for (int n = 0; n < 3000; n++) begin
      wr_en = ($urandom_range(0, 3) != 0);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = {$urandom, $urandom};
      alloc_en = ($urandom_range(0, 2) != 0);
      alloc_addr = 5'($urandom_range(0, 31));
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr
               : 5'($urandom_range(0, 31));
      rd_addr2 = ($urandom_range(0, 3) == 0) ? alloc_addr
               : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) begin
        wr_en = 1'b0;
        #2 reset_n = 1'b0;
        m_clear();
        step();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
